// File: rtl/pcd8544_spi_tx.sv
// Byte-wide SPI transmitter for the PCD8544 LCD: generates the panel's power-on
// reset, then captures one byte per request and shifts it out MSB-first.
module pcd8544_spi_tx #(
  parameter int RST_CYCLES = 100,
  parameter int BOOT_WAIT  = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        start,
  input  logic        command,
  input  logic [15:0] div_factor,
  output logic        mosi,
  output logic        sclk,
  output logic        sce,
  output logic        dc,
  output logic        rst,
  output logic        busy,
  output logic        avail
);

  localparam int CNT_MAX = (RST_CYCLES > BOOT_WAIT) ? RST_CYCLES : BOOT_WAIT;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_WAIT - 1);

  localparam logic [2:0] ST_LCD_RST = 3'd0;
  localparam logic [2:0] ST_BOOT    = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  logic [2:0]    state_q,     state_d;
  logic [CW-1:0] boot_cnt_q,  boot_cnt_d;
  logic [15:0]   half_cnt_q,  half_cnt_d;
  logic [15:0]   half_last_q, half_last_d;
  logic [2:0]    bit_cnt_q,   bit_cnt_d;
  logic [6:0]    shreg_q,     shreg_d;
  logic          mosi_q,  mosi_d;
  logic          sclk_q,  sclk_d;
  logic          sce_q,   sce_d;
  logic          dc_q,    dc_d;
  logic          rst_q,   rst_d;
  logic          busy_q,  busy_d;
  logic          avail_q, avail_d;
  logic          half_tick;

  // Terminal count of the half-period counter; half_last holds D-1.
  assign half_tick = (half_cnt_q == half_last_q);

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    half_cnt_d  = half_cnt_q;
    half_last_d = half_last_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    mosi_d      = mosi_q;
    sclk_d      = sclk_q;
    sce_d       = sce_q;
    dc_d        = dc_q;
    rst_d       = rst_q;
    busy_d      = busy_q;
    avail_d     = 1'b0;

    case (state_q)
      ST_LCD_RST: begin
        rst_d = 1'b0;
        if (boot_cnt_q == RST_LAST) begin
          rst_d      = 1'b1;
          boot_cnt_d = '0;
          state_d    = ST_BOOT;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          boot_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        busy_d = 1'b0;
        sce_d  = 1'b1;
        sclk_d = 1'b0;
        if (start) begin
          shreg_d     = data_in[6:0];
          mosi_d      = data_in[7];
          dc_d        = command;
          half_last_d = (div_factor == 16'd0) ? 16'd0 : (div_factor - 16'd1);
          half_cnt_d  = '0;
          bit_cnt_d   = '0;
          sce_d       = 1'b0;
          busy_d      = 1'b1;
          avail_d     = 1'b1;
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (half_tick) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
          // Falling edge: present the next bit a full half-period before the LCD samples it.
          if (sclk_q) begin
            if (bit_cnt_q == 3'd7) begin
              sce_d   = 1'b1;
              mosi_d  = 1'b0;
              state_d = ST_GAP;
            end else begin
              mosi_d    = shreg_q[6];
              shreg_d   = {shreg_q[5:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
      end

      ST_GAP: begin
        if (half_tick) begin
          half_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          half_cnt_d = half_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = ST_LCD_RST;
        boot_cnt_d = '0;
        rst_d      = 1'b0;
        busy_d     = 1'b1;
        sce_d      = 1'b1;
        sclk_d     = 1'b0;
        mosi_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LCD_RST;
      boot_cnt_q  <= '0;
      half_cnt_q  <= '0;
      half_last_q <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      mosi_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sce_q       <= 1'b1;
      dc_q        <= 1'b0;
      rst_q       <= 1'b0;
      busy_q      <= 1'b1;
      avail_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      half_cnt_q  <= half_cnt_d;
      half_last_q <= half_last_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      mosi_q      <= mosi_d;
      sclk_q      <= sclk_d;
      sce_q       <= sce_d;
      dc_q        <= dc_d;
      rst_q       <= rst_d;
      busy_q      <= busy_d;
      avail_q     <= avail_d;
    end
  end

  assign mosi  = mosi_q;
  assign sclk  = sclk_q;
  assign sce   = sce_q;
  assign dc    = dc_q;
  assign rst   = rst_q;
  assign busy  = busy_q;
  assign avail = avail_q;

endmodule

// File: tb/tb_pcd8544_spi_tx.sv
// Bench for pcd8544_spi_tx: per-bit expectations queued when a byte is driven,
// popped and compared at every sclk rising edge; timing checked per byte.
module tb_pcd8544_spi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        start = 1'b0;
  logic        command = 1'b0;
  logic [15:0] div_factor = 16'd1;
  logic        mosi, sclk, sce, dc, rst, busy, avail;

  pcd8544_spi_tx #(.RST_CYCLES(100), .BOOT_WAIT(100)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .start(start),
    .command(command), .div_factor(div_factor), .mosi(mosi), .sclk(sclk),
    .sce(sce), .dc(dc), .rst(rst), .busy(busy), .avail(avail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic mosi;
    logic dc;
    int   rel;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        cmd;
    logic [15:0] div;
    logic [15:0] div_after;
    int          exp_d;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   avail_seen = 0;
  int   rise_seen = 0;
  int   last_e0 = 0;
  logic sclk_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample away from the active edge and score any sclk rise.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (avail) begin
      avail_seen++;
      last_e0 = cyc;
    end
    if (sclk && !sclk_prev) begin
      rise_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_sclk_rise", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("mosi_at_rise", int'(mosi), int'(e.mosi));
        chk("dc_at_rise", int'(dc), int'(e.dc));
        chk("sce_at_rise", int'(sce), 0);
        chk("rise_time", cyc - last_e0, e.rel);
      end
    end
    sclk_prev = sclk;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic c, input int dd, input int nbits);
    exp_t e;
    for (int k = 0; k < nbits; k++) begin
      e.mosi = d[7-k];
      e.dc   = c;
      e.rel  = dd * (2 * k + 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 400) begin
      step();
      g++;
    end
    chk("wait_idle", int'(busy), 0);
  endtask

  // Runs from the last reset edge (r0) through BOOT into IDLE.
  task automatic boot_check(input int r0, input bit pulse_in_boot);
    int first_rst = -1, first_free = -1, bad_pins = 0, n;
    int av0 = avail_seen, rs0 = rise_seen;
    for (int i = 0; i < 210; i++) begin
      step();
      n = cyc - r0;
      if (pulse_in_boot && n == 150) begin
        data_in = 8'hFF; command = 1'b1; div_factor = 16'd1; start = 1'b1;
      end
      if (n == 151) start = 1'b0;
      if (first_rst < 0 && rst) first_rst = n;
      if (first_free < 0 && !busy) first_free = n;
      if (!sce || sclk) bad_pins++;
    end
    chk("rst_release_cycle", first_rst, 100);
    chk("busy_release_cycle", first_free, 200);
    chk("sce_sclk_idle_during_boot", bad_pins, 0);
    chk("no_avail_during_boot", avail_seen - av0, 0);
    chk("no_sclk_during_boot", rise_seen - rs0, 0);
    $display("boot sequence from cycle %0d observed", r0);
  endtask

  task automatic run_byte(input vec_t v);
    int e0, n, first_sce = -1, first_idle = -1;
    int av0, rs0;
    wait_idle();
    av0 = avail_seen;
    rs0 = rise_seen;
    data_in = v.data; command = v.cmd; div_factor = v.div; start = 1'b1;
    push_byte(v.data, v.cmd, v.exp_d, 8);
    step();
    chk("avail_after_capture", int'(avail), 1);
    chk("sce_low_at_capture", int'(sce), 0);
    e0 = cyc;
    start = 1'b0; div_factor = v.div_after; data_in = ~v.data; command = ~v.cmd;
    for (int i = 0; i < 17 * v.exp_d + 4; i++) begin
      step();
      n = cyc - e0;
      if (first_sce < 0 && sce) begin
        first_sce = n;
        chk("mosi_zero_after_byte", int'(mosi), 0);
      end
      if (first_idle < 0 && !busy) first_idle = n;
    end
    chk("sce_high_time", first_sce, 16 * v.exp_d);
    chk("busy_low_time", first_idle, 17 * v.exp_d);
    chk("avail_pulses", avail_seen - av0, 1);
    chk("sclk_rises", rise_seen - rs0, 8);
    chk("dc_retained", int'(dc), int'(v.cmd));
    $display("byte 0x%02h dc=%0d D=%0d sent", v.data, v.cmd, v.exp_d);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   e0, e1, r0, g, av0, rs0;

    vecs[0] = '{data: 8'h96, cmd: 1'b1, div: 16'd3, div_after: 16'd1, exp_d: 3};
    vecs[1] = '{data: 8'hA5, cmd: 1'b0, div: 16'd2, div_after: 16'd2, exp_d: 2};
    vecs[2] = '{data: 8'hFF, cmd: 1'b1, div: 16'd0, div_after: 16'd0, exp_d: 1};
    vecs[3] = '{data: 8'h3C, cmd: 1'b1, div: 16'd3, div_after: 16'd7, exp_d: 3};
    vecs[4] = '{data: 8'h81, cmd: 1'b0, div: 16'd1, div_after: 16'd1, exp_d: 1};

    // Reset values, then power-on sequence with a stray start pulse in BOOT.
    reset = 1'b1;
    repeat (3) step();
    chk("reset_mosi", int'(mosi), 0);
    chk("reset_sclk", int'(sclk), 0);
    chk("reset_sce", int'(sce), 1);
    chk("reset_dc", int'(dc), 0);
    chk("reset_rst", int'(rst), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_avail", int'(avail), 0);
    reset = 1'b0;
    r0 = cyc;
    boot_check(r0, 1'b1);

    for (int i = 0; i < 5; i++) run_byte(vecs[i]);

    // Back-to-back bytes with start held; data changes on the cycle after avail.
    wait_idle();
    av0 = avail_seen;
    rs0 = rise_seen;
    data_in = 8'hA5; command = 1'b0; div_factor = 16'd2; start = 1'b1;
    push_byte(8'hA5, 1'b0, 2, 8);
    step();
    chk("chain_first_avail", int'(avail), 1);
    e0 = cyc;
    data_in = 8'h0C; command = 1'b1;
    push_byte(8'h0C, 1'b1, 2, 8);
    g = 0;
    do begin
      step();
      g++;
    end while (!avail && g < 60);
    e1 = cyc;
    chk("chain_second_avail", int'(avail), 1);
    chk("chain_capture_spacing", e1 - e0, 35);
    start = 1'b0;
    repeat (40) step();
    chk("chain_avail_pulses", avail_seen - av0, 2);
    chk("chain_sclk_rises", rise_seen - rs0, 16);
    chk("chain_dc_retained", int'(dc), 1);
    $display("chained bytes 0xa5,0x0c sent");

    // Reset mid-byte at E0+9: only the first two bits ever reach the pins.
    wait_idle();
    data_in = 8'h5A; command = 1'b1; div_factor = 16'd2; start = 1'b1;
    push_byte(8'h5A, 1'b1, 2, 2);
    step();
    chk("abort_avail", int'(avail), 1);
    e0 = cyc;
    start = 1'b0;
    while (cyc - e0 < 8) step();
    reset = 1'b1;
    step();
    chk("abort_sce", int'(sce), 1);
    chk("abort_sclk", int'(sclk), 0);
    chk("abort_rst", int'(rst), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_avail_low", int'(avail), 0);
    chk("abort_dc", int'(dc), 0);
    reset = 1'b0;
    r0 = cyc;
    boot_check(r0, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("mid-byte reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcd8544_spi_tx.md
Name: pcd8544_spi_tx

Overview:
- Byte-level SPI transmitter for the PCD8544 (Nokia 5110) 84x48 LCD. It sits directly downstream of the display configuration/drawing sequencers and directly drives the LCD pins.
- An upstream sequencer presents a byte plus a data/command flag. This block captures it, serializes it MSB-first, and pulses `avail` so the sequencer can advance to its next byte.
- After reset it also generates the LCD's power-on reset pulse.

Parameters:
- RST_CYCLES, 100: clock cycles that `rst` is held low after reset.
- BOOT_WAIT, 100: clock cycles after `rst` releases before the first byte is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transmit.
- start  in  1  level request: transmit `data_in` while high.
- command  in  1  value driven on `dc` for this byte (0 = command, 1 = data).
- div_factor  in  16  SCLK half-period in clk cycles; 0 is treated as 1.
- mosi  out  1  serial data to the LCD, MSB first.
- sclk  out  1  serial clock; idles low.
- sce  out  1  chip enable, active low.
- dc  out  1  data/command select.
- rst  out  1  LCD reset, active low.
- busy  out  1  high whenever the block is not in IDLE.
- avail  out  1  one-cycle pulse: byte captured.

Behaviour:
- Reset values (all outputs registered, applied on any clk edge with reset=1, including mid-byte):
  - mosi=0, sclk=0, sce=1, dc=0, rst=0, busy=1, avail=0.
  - State = LCD_RST; all counters cleared. An aborted byte is simply dropped.
- LCD_RST:
  - `rst`=0 for RST_CYCLES cycles, then `rst`=1 and go to BOOT.
- BOOT:
  - Wait BOOT_WAIT cycles, then go to IDLE.
  - `rst` stays 1 from here on until the next reset.
  - `start` is ignored in LCD_RST and BOOT.
- IDLE:
  - Outputs: busy=0, sce=1, sclk=0.
  - On an edge with start=1 (capture edge E0):
    - Latch data_in into the shift register and command into `dc`.
    - Latch D = max(div_factor, 1).
    - Set sce=0 and mosi=data_in[7], go to SHIFT.
    - Set avail=1 for the single following cycle only.
  - start=0: remain in IDLE, outputs unchanged.
- SHIFT:
  - Half-period counter runs from 0 to D-1.
  - sclk rises at E0+D·(2k+1) and falls at E0+D·(2k+2), for k=0..7.
  - At each falling edge except the last, mosi is updated to the next lower bit. The LCD samples on the rising edge, so mosi is stable for D cycles before each rising edge.
  - After the 8th falling edge (E0+16D): sce=1, mosi=0, go to GAP.
- GAP:
  - sce held high for D cycles; at E0+17D go to IDLE (busy=0).
  - If start is still high, the next capture is at E0+17D+1. Throughput is one byte per 17D+1 cycles.
- Capture rules:
  - data_in, command and div_factor are sampled only at the capture edge. Changes during SHIFT/GAP have no effect.
  - The upstream sequencer changes data_in on the cycle after `avail`. Because SHIFT lasts ≥16 cycles, no byte is ever captured twice.
  - start dropping mid-byte does not abort the byte; the byte completes and the block stays in IDLE.
- dc is held from E0 through the end of GAP and retains its value in IDLE.
- Counters:
  - Half-period counter is 16 bits; bit counter is 3 bits.
  - RST/BOOT counter is sized to max(RST_CYCLES, BOOT_WAIT).
  - No wrap is possible; each counter is reloaded at every state entry.

Test Plan:
- Reset, then release with start=0 → rst low for exactly 100 cycles then high; busy=1 until cycle 200, then busy=0; sce=1 and sclk=0 throughout.
- Boot done, start=1, data_in=8'hA5, command=0, div_factor=2 → avail high exactly 1 cycle after E0; 8 sclk rising edges at E0+2, 6, 10, …, 30; mosi sampled at the rising edges = 1,0,1,0,0,1,0,1; dc=0; sce low E0..E0+31, high at E0+32; busy=0 at E0+34.
- start held high with data_in switched to 8'h0C and command=1 on the cycle after avail → second byte captured at E0+35 with dc=1 and serializes 0,0,0,0,1,1,0,0; only two avail pulses occur.
- div_factor=0 with data_in=8'hFF → behaves as D=1: sclk toggles every cycle, 8 rising edges, mosi=1 at every one.
- reset asserted at E0+9 mid-byte → next edge: sce=1, sclk=0, rst=0, busy=1, avail=0; full LCD_RST/BOOT sequence repeats; no further sclk edges until a new capture.
- start pulsed for 1 cycle in BOOT, then start=1 for 1 cycle in IDLE, and div_factor changed mid-byte → no capture during BOOT; exactly one byte sent; sclk period stays at the div_factor value captured at E0.
